// File: rtl/ballot_session_ctrl_pkg.sv
// Shared definitions for the ballot session controller: state encoding and
// the sizing helper used for the internal timers.
package ballot_session_ctrl_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE    = 3'd0,
      ST_OPEN    = 3'd1,
      ST_BALLOT  = 3'd2,
      ST_CONFIRM = 3'd3,
      ST_CLOSED  = 3'd4
   } state_t;

   // Bits needed to count 0..term-1; never less than one bit.
   function automatic int timer_width(input int term);
      return (term > 1) ? $clog2(term) : 1;
   endfunction

endpackage

// File: rtl/ballot_session_ctrl_timer.sv
// Up-counter with load/enable and a terminal-count flag at TERM-1.
// Used for both the ballot timeout and the confirm lockout.
module ballot_session_ctrl_timer #(
   parameter int WIDTH = 4,
   parameter int TERM  = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic en,
   output logic tc
);

   localparam logic [WIDTH-1:0] LAST = WIDTH'(TERM - 1);

   logic [WIDTH-1:0] count;

   // Count register: load restarts from zero, enable advances by one.
   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignment so every flop in the
      // design samples pre-edge values regardless of block ordering.
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= '0;
      end else if (en) begin
         count <= count + 1'b1;
      end
   end

   assign tc = (count == LAST);

endmodule

// File: rtl/ballot_session_ctrl.sv
// Session sequencer for the voting machine: opens a poll, gates each issued
// ballot down to at most one counter increment, enforces a confirm lockout,
// and shows stored tallies once the poll is closed.
module ballot_session_ctrl
   import ballot_session_ctrl_pkg::*;
#(
   parameter int NUM_CAND       = 4,
   parameter int CNT_W          = 10,
   parameter int LOCK_CYCLES    = 100000000,
   parameter int BALLOT_TIMEOUT = 500000000
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      open_poll,
   input  logic                      close_poll,
   input  logic                      issue_ballot,
   input  logic [NUM_CAND-1:0]       vote_pulse,
   input  logic [NUM_CAND-1:0]       show_sel,
   input  logic [NUM_CAND*CNT_W-1:0] tally_flat,
   output logic                      clr_counts,
   output logic [NUM_CAND-1:0]       inc_en,
   output logic                      ballot_active,
   output logic                      confirm,
   output logic                      spoiled,
   output logic [CNT_W-1:0]          ballots_cast,
   output logic [CNT_W-1:0]          result,
   output logic [STATE_W-1:0]        state_o
);

   localparam int TO_W   = timer_width(BALLOT_TIMEOUT);
   localparam int LOCK_W = timer_width(LOCK_CYCLES);

   state_t           state;
   logic             pend_close;
   logic             vote_any;
   logic             vote_one;
   logic             vote_multi;
   logic             to_load;
   logic             to_en;
   logic             to_tc;
   logic             lock_load;
   logic             lock_en;
   logic             lock_tc;
   logic [CNT_W-1:0] sel_tally;
   logic [CNT_W-1:0] cast_next;

   // Clearing the lowest set bit leaves something only if two or more were set.
   assign vote_any   = |vote_pulse;
   assign vote_multi = |(vote_pulse & (vote_pulse - NUM_CAND'(1)));
   assign vote_one   = vote_any && !vote_multi;

   assign cast_next  = (ballots_cast == '1) ? ballots_cast : ballots_cast + 1'b1;

   assign to_load    = (state == ST_OPEN) && !close_poll && issue_ballot;
   assign to_en      = (state == ST_BALLOT) && !vote_any && !to_tc;
   assign lock_load  = (state == ST_BALLOT) && vote_any;
   assign lock_en    = (state == ST_CONFIRM) && !lock_tc;

   ballot_session_ctrl_timer #(
      .WIDTH (TO_W),
      .TERM  (BALLOT_TIMEOUT)
   ) u_timeout (
      .clk  (clk),
      .rst  (rst),
      .load (to_load),
      .en   (to_en),
      .tc   (to_tc)
   );

   ballot_session_ctrl_timer #(
      .WIDTH (LOCK_W),
      .TERM  (LOCK_CYCLES)
   ) u_lock (
      .clk  (clk),
      .rst  (rst),
      .load (lock_load),
      .en   (lock_en),
      .tc   (lock_tc)
   );

   // Display mux: scan high to low so the lowest-index selected candidate wins.
   always_comb begin
      // NOTE: default assignment first so no path through the loop leaves
      // sel_tally unassigned and infers a latch.
      sel_tally = '0;
      for (int i = NUM_CAND - 1; i >= 0; i--) begin
         if (show_sel[i]) sel_tally = tally_flat[i*CNT_W +: CNT_W];
      end
   end

   // Session FSM with all outputs registered; pulses default low every cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_IDLE;
         pend_close    <= 1'b0;
         clr_counts    <= 1'b0;
         inc_en        <= '0;
         ballot_active <= 1'b0;
         confirm       <= 1'b0;
         spoiled       <= 1'b0;
         ballots_cast  <= '0;
         result        <= '0;
      end else begin
         clr_counts <= 1'b0;
         inc_en     <= '0;
         spoiled    <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (open_poll) begin
                  state        <= ST_OPEN;
                  clr_counts   <= 1'b1;
                  ballots_cast <= '0;
                  pend_close   <= 1'b0;
               end
            end
            ST_OPEN: begin
               if (close_poll) begin
                  state <= ST_CLOSED;
               end else if (issue_ballot) begin
                  state         <= ST_BALLOT;
                  ballot_active <= 1'b1;
               end
            end
            ST_BALLOT: begin
               // A close request waits until the ballot in hand has resolved.
               if (close_poll) pend_close <= 1'b1;
               if (vote_one) begin
                  inc_en        <= vote_pulse;
                  ballots_cast  <= cast_next;
                  state         <= ST_CONFIRM;
                  ballot_active <= 1'b0;
                  confirm       <= 1'b1;
               end else if (vote_multi) begin
                  spoiled       <= 1'b1;
                  ballots_cast  <= cast_next;
                  state         <= ST_CONFIRM;
                  ballot_active <= 1'b0;
                  confirm       <= 1'b1;
               end else if (to_tc) begin
                  spoiled       <= 1'b1;
                  ballots_cast  <= cast_next;
                  state         <= ST_OPEN;
                  ballot_active <= 1'b0;
               end
            end
            ST_CONFIRM: begin
               if (lock_tc) begin
                  confirm <= 1'b0;
                  state   <= (pend_close || close_poll) ? ST_CLOSED : ST_OPEN;
               end
            end
            ST_CLOSED: begin
               // Terminal: only rst leaves; an empty select holds the last value.
               if (|show_sel) result <= sel_tally;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign state_o = state;

endmodule
